regfile_fwd: RTL and testbench

//  Integer register file for the 5-stage RISC-V core; sole consumer of the WB write port driven by the MEM/WB register.

---
 rtl/regfile_fwd_pkg.sv | 25 ++
 rtl/regfile_array.sv | 37 +++
 rtl/regfile_fwd.sv | 119 +++++++++++
 tb/tb_regfile_fwd.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_fwd_pkg.sv
// Shared types and constants for the ID-stage register file with operand forwarding.
package regfile_fwd_pkg;

   localparam int REG_NUM = 32;
   localparam int REG_W   = 32;
   localparam int ADDR_W  = $clog2(REG_NUM);

   localparam logic [REG_W-1:0]  ZERO_WORD    = {REG_W{1'b0}};
   localparam logic [ADDR_W-1:0] NOP_REG_ADDR = {ADDR_W{1'b0}};
   localparam logic              WRITE_ENABLE = 1'b1;
   localparam logic              READ_ENABLE  = 1'b1;
   localparam logic              STOP         = 1'b1;
   localparam logic              NO_STOP      = 1'b0;
   localparam logic              RST_ENABLE   = 1'b1;

   // Which producer supplies a read port; ordered youngest-first after ZERO.
   typedef enum logic [2:0] {
      SRC_ZERO  = 3'd0,
      SRC_EX    = 3'd1,
      SRC_MEM   = 3'd2,
      SRC_WB    = 3'd3,
      SRC_ARRAY = 3'd4
   } fwd_src_e;

endpackage : regfile_fwd_pkg

// File: rtl/regfile_array.sv
// Architectural register storage: one synchronous write port with x0 masking and
// two raw asynchronous read ports (no forwarding, no reset gating on reads).
module regfile_array
   import regfile_fwd_pkg::*;
#(
   parameter int NUM = REG_NUM,
   parameter int W   = REG_W,
   parameter int AW  = ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr1_i,
   input  logic [AW-1:0] raddr2_i,
   output logic [W-1:0]  rdata1_o,
   output logic [W-1:0]  rdata2_o
);

   logic [W-1:0] regs_q [NUM];

   // Reset wins over a same-cycle write; x0 is never stored into.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         for (int i = 0; i < NUM; i++) begin
            regs_q[i] <= {W{1'b0}};
         end
      end else if (we_i && (waddr_i != {AW{1'b0}})) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = regs_q[raddr1_i];
   assign rdata2_o = regs_q[raddr2_i];

endmodule : regfile_array

// File: rtl/regfile_fwd.sv
// ID-stage register file: two read ports with EX/MEM/WB forwarding and a
// combinational load-use stall request.
module regfile_fwd
   import regfile_fwd_pkg::*;
#(
   parameter int REG_NUM = regfile_fwd_pkg::REG_NUM,
   parameter int REG_W   = regfile_fwd_pkg::REG_W,
   parameter int ADDR_W  = regfile_fwd_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we_i,
   input  logic [ADDR_W-1:0] wb_wd_i,
   input  logic [REG_W-1:0]  wb_wdata_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_wd_i,
   input  logic [REG_W-1:0]  mem_wdata_i,
   input  logic              ex_we_i,
   input  logic [ADDR_W-1:0] ex_wd_i,
   input  logic [REG_W-1:0]  ex_wdata_i,
   input  logic              ex_is_load_i,
   input  logic              re1_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   input  logic              re2_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [REG_W-1:0]  rdata1_o,
   output logic [REG_W-1:0]  rdata2_o,
   output logic              stallreq_o
);

   logic [REG_W-1:0] arr_rdata1_s;
   logic [REG_W-1:0] arr_rdata2_s;
   fwd_src_e         src1_s;
   fwd_src_e         src2_s;

   regfile_array #(
      .NUM (REG_NUM),
      .W   (REG_W),
      .AW  (ADDR_W)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .we_i     (wb_we_i),
      .waddr_i  (wb_wd_i),
      .wdata_i  (wb_wdata_i),
      .raddr1_i (raddr1_i),
      .raddr2_i (raddr2_i),
      .rdata1_o (arr_rdata1_s),
      .rdata2_o (arr_rdata2_s)
   );

   // Youngest producer wins; a load in EX has no data yet and is never a source.
   function automatic fwd_src_e pick_src(
      input logic              rst_v,
      input logic              re,
      input logic [ADDR_W-1:0] raddr,
      input logic              ex_we,
      input logic [ADDR_W-1:0] ex_wd,
      input logic              ex_is_load,
      input logic              mem_we,
      input logic [ADDR_W-1:0] mem_wd,
      input logic              wb_we,
      input logic [ADDR_W-1:0] wb_wd
   );
      fwd_src_e src;
      if (rst_v || !re || (raddr == {ADDR_W{1'b0}})) begin
         src = SRC_ZERO;
      end else if (ex_we && (ex_wd == raddr) && !ex_is_load) begin
         src = SRC_EX;
      end else if (mem_we && (mem_wd == raddr)) begin
         src = SRC_MEM;
      end else if (wb_we && (wb_wd == raddr)) begin
         src = SRC_WB;
      end else begin
         src = SRC_ARRAY;
      end
      return src;
   endfunction

   function automatic logic [REG_W-1:0] mux_src(
      input fwd_src_e         src,
      input logic [REG_W-1:0] ex_d,
      input logic [REG_W-1:0] mem_d,
      input logic [REG_W-1:0] wb_d,
      input logic [REG_W-1:0] arr_d
   );
      logic [REG_W-1:0] d;
      case (src)
         SRC_EX:    d = ex_d;
         SRC_MEM:   d = mem_d;
         SRC_WB:    d = wb_d;
         SRC_ARRAY: d = arr_d;
         default:   d = {REG_W{1'b0}};
      endcase
      return d;
   endfunction

   // Read-port forwarding selection and data muxing.
   always_comb begin
      src1_s   = pick_src(rst, re1_i, raddr1_i, ex_we_i, ex_wd_i, ex_is_load_i,
                          mem_we_i, mem_wd_i, wb_we_i, wb_wd_i);
      src2_s   = pick_src(rst, re2_i, raddr2_i, ex_we_i, ex_wd_i, ex_is_load_i,
                          mem_we_i, mem_wd_i, wb_we_i, wb_wd_i);
      rdata1_o = mux_src(src1_s, ex_wdata_i, mem_wdata_i, wb_wdata_i, arr_rdata1_s);
      rdata2_o = mux_src(src2_s, ex_wdata_i, mem_wdata_i, wb_wdata_i, arr_rdata2_s);
   end

   // Load in EX whose destination is read by ID must hold the front end one cycle.
   always_comb begin
      stallreq_o = NO_STOP;
      if (!rst && ex_we_i && ex_is_load_i && (ex_wd_i != NOP_REG_ADDR) &&
          ((re1_i && (raddr1_i == ex_wd_i)) || (re2_i && (raddr2_i == ex_wd_i)))) begin
         stallreq_o = STOP;
      end else begin
         stallreq_o = NO_STOP;
      end
   end

endmodule : regfile_fwd

// File: tb/tb_regfile_fwd.sv
// Directed scoreboard bench for regfile_fwd: stimulus pushes expectations,
// a negedge monitor pops and compares.
module tb_regfile_fwd;

   localparam int AW = 5;
   localparam int W  = 32;

   logic          clk;
   logic          rst;
   logic          wb_we;
   logic [AW-1:0] wb_wd;
   logic [W-1:0]  wb_wdata;
   logic          mem_we;
   logic [AW-1:0] mem_wd;
   logic [W-1:0]  mem_wdata;
   logic          ex_we;
   logic [AW-1:0] ex_wd;
   logic [W-1:0]  ex_wdata;
   logic          ex_is_load;
   logic          re1;
   logic [AW-1:0] raddr1;
   logic          re2;
   logic [AW-1:0] raddr2;
   logic [W-1:0]  rdata1;
   logic [W-1:0]  rdata2;
   logic          stallreq;

   typedef struct packed {
      logic [7:0]   id;
      logic         chk_d;
      logic [W-1:0] e1;
      logic [W-1:0] e2;
      logic         es;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   regfile_fwd dut (
      .clk          (clk),
      .rst          (rst),
      .wb_we_i      (wb_we),
      .wb_wd_i      (wb_wd),
      .wb_wdata_i   (wb_wdata),
      .mem_we_i     (mem_we),
      .mem_wd_i     (mem_wd),
      .mem_wdata_i  (mem_wdata),
      .ex_we_i      (ex_we),
      .ex_wd_i      (ex_wd),
      .ex_wdata_i   (ex_wdata),
      .ex_is_load_i (ex_is_load),
      .re1_i        (re1),
      .raddr1_i     (raddr1),
      .re2_i        (re2),
      .raddr2_i     (raddr2),
      .rdata1_o     (rdata1),
      .rdata2_o     (rdata2),
      .stallreq_o   (stallreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: outputs are stable mid-cycle; compare against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.chk_d) begin
            checks++;
            if (rdata1 !== e.e1) begin
               errors++;
               $display("FAIL step%0d rdata1: got %h expected %h", e.id, rdata1, e.e1);
            end
            checks++;
            if (rdata2 !== e.e2) begin
               errors++;
               $display("FAIL step%0d rdata2: got %h expected %h", e.id, rdata2, e.e2);
            end
         end
         checks++;
         if (stallreq !== e.es) begin
            errors++;
            $display("FAIL step%0d stallreq: got %b expected %b", e.id, stallreq, e.es);
         end
      end
   end

   task automatic idle();
      wb_we = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
      mem_we = 1'b0; mem_wd = 5'd0; mem_wdata = 32'h0;
      ex_we = 1'b0; ex_wd = 5'd0; ex_wdata = 32'h0; ex_is_load = 1'b0;
      re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
   endtask

   task automatic step(input logic chk_d, input logic [W-1:0] e1,
                       input logic [W-1:0] e2, input logic es);
      exp_t e;
      step_id++;
      e.id = step_id[7:0]; e.chk_d = chk_d; e.e1 = e1; e.e2 = e2; e.es = es;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      // Reset gates outputs even with a load-use pattern present.
      re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd3;
      ex_we = 1'b1; ex_wd = 5'd3; ex_is_load = 1'b1; ex_wdata = 32'h1;
      step(1'b1, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;

      idle(); wb_we = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEADBEEF; re1 = 1'b1; raddr1 = 5'd5;
      step(1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
      idle(); re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
      step(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      idle(); rst = 1'b1; wb_we = 1'b1; wb_wd = 5'd6; wb_wdata = 32'h11111111;
      re1 = 1'b1; raddr1 = 5'd5;
      step(1'b1, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      idle(); re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd6;
      step(1'b1, 32'h0, 32'h0, 1'b0);

      // x0 is neither written nor forwarded.
      idle(); wb_we = 1'b1; wb_wd = 5'd0; wb_wdata = 32'h1234; re1 = 1'b1; raddr1 = 5'd0;
      step(1'b1, 32'h0, 32'h0, 1'b0);
      idle(); ex_we = 1'b1; ex_wd = 5'd0; ex_wdata = 32'hFF; mem_we = 1'b1; mem_wd = 5'd0;
      mem_wdata = 32'h77; re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
      step(1'b1, 32'h0, 32'h0, 1'b0);

      // Forwarding priority on x7.
      idle(); wb_we = 1'b1; wb_wd = 5'd7; wb_wdata = 32'd1;
      step(1'b1, 32'h0, 32'h0, 1'b0);
      idle(); re1 = 1'b1; raddr1 = 5'd7;
      step(1'b1, 32'd1, 32'h0, 1'b0);
      idle(); wb_we = 1'b1; wb_wd = 5'd7; wb_wdata = 32'd2; mem_we = 1'b1; mem_wd = 5'd7;
      mem_wdata = 32'd3; ex_we = 1'b1; ex_wd = 5'd7; ex_wdata = 32'd4;
      re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
      step(1'b1, 32'd4, 32'd4, 1'b0);
      ex_we = 1'b0;
      step(1'b1, 32'd3, 32'd3, 1'b0);
      mem_we = 1'b0;
      step(1'b1, 32'd2, 32'd2, 1'b0);
      wb_we = 1'b0;
      step(1'b1, 32'd2, 32'd2, 1'b0);
      // Load in EX on x7 stalls; data is don't-care.
      idle(); ex_we = 1'b1; ex_wd = 5'd7; ex_is_load = 1'b1; mem_we = 1'b1; mem_wd = 5'd7;
      mem_wdata = 32'd3; re1 = 1'b1; raddr1 = 5'd7;
      step(1'b0, 32'h0, 32'h0, 1'b1);

      // WB write-through in the same cycle.
      idle(); wb_we = 1'b1; wb_wd = 5'd9; wb_wdata = 32'hA5A5A5A5;
      re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd9;
      step(1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);

      // Load-use detection.
      idle(); ex_we = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
      step(1'b0, 32'h0, 32'h0, 1'b1);
      re2 = 1'b0;
      step(1'b1, 32'h0, 32'h0, 1'b0);
      ex_wd = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
      step(1'b1, 32'h0, 32'h0, 1'b0);
      ex_wd = 5'd3; re2 = 1'b0; re1 = 1'b1; raddr1 = 5'd3;
      step(1'b0, 32'h0, 32'h0, 1'b1);

      // Read-enable gating, mixed with MEM and EX forwarding.
      idle(); wb_we = 1'b1; wb_wd = 5'd4; wb_wdata = 32'h55;
      step(1'b1, 32'h0, 32'h0, 1'b0);
      idle(); re1 = 1'b0; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd4;
      step(1'b1, 32'h0, 32'h55, 1'b0);
      idle(); mem_we = 1'b1; mem_wd = 5'd10; mem_wdata = 32'hCAFE0000;
      re1 = 1'b1; raddr1 = 5'd10; re2 = 1'b1; raddr2 = 5'd4;
      step(1'b1, 32'hCAFE0000, 32'h55, 1'b0);
      idle(); ex_we = 1'b1; ex_wd = 5'd11; ex_wdata = 32'h1;
      re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd11;
      step(1'b1, 32'h55, 32'h1, 1'b0);
      idle();

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_regfile_fwd
